// File: rtl/oqpsk_tx_frame_ctrl.sv
// Frame sequencer for the OQPSK transmitter: preamble, SFD, payload, optional CRC-16, tail.
// Optional feature macro: OQPSK_TX_CRC_EN (appends CRC-16-CCITT after the payload).
module oqpsk_tx_frame_ctrl #(
  parameter int         PRE_BITS    = 32,
  parameter logic [7:0] SFD_PATTERN = 8'hA7,
  parameter int         TAIL_BITS   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       bit_stb,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       bit_out,
  output logic       mod_en,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int MAX_A = (PRE_BITS > TAIL_BITS) ? PRE_BITS : TAIL_BITS;
  localparam int MAX_B = (MAX_A > 16) ? MAX_A : 16;
  localparam int CW    = $clog2(MAX_B + 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_BITS - 1);
  localparam logic [CW-1:0] TAIL_LAST = CW'(TAIL_BITS - 1);
  localparam logic [CW-1:0] BYTE_LAST = CW'(7);
  localparam logic [CW-1:0] ONE       = CW'(1);

`ifdef OQPSK_TX_CRC_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, PRE = 3'd1, SFD = 3'd2, PAY = 3'd3, CRC = 3'd4, TAIL = 3'd5
  } state_t;

  localparam logic [CW-1:0] CRC_LAST = CW'(15);

  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic din);
    logic fb;
    fb = crc_in[15] ^ din;
    return {crc_in[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  logic [15:0] crc;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, PRE = 3'd1, SFD = 3'd2, PAY = 3'd3, TAIL = 3'd5
  } state_t;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    shreg;
  logic          cur_last;
  logic          hold_vld;
  logic [7:0]    hold_data;
  logic          hold_last;
  logic          last_seen;
  logic          accept;

  assign byte_ready = busy & ~hold_vld & ~last_seen;
  assign accept     = byte_valid & byte_ready;

  // Frame sequencer: bit_out holds the bit loaded on the most recent strobe (or on start).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= 8'h00;
      cur_last  <= 1'b0;
      hold_vld  <= 1'b0;
      hold_data <= 8'h00;
      hold_last <= 1'b0;
      last_seen <= 1'b0;
      bit_out   <= 1'b0;
      mod_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
`ifdef OQPSK_TX_CRC_EN
      crc       <= 16'hFFFF;
`endif
    end else begin
      done <= 1'b0;
      // Ready is low whenever the holding register is full, so this never collides with a transfer.
      if (accept) begin
        hold_vld  <= 1'b1;
        hold_data <= byte_data;
        hold_last <= byte_last;
        if (byte_last) begin
          last_seen <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= PRE;
            cnt       <= '0;
            bit_out   <= 1'b1;
            mod_en    <= 1'b1;
            busy      <= 1'b1;
            underrun  <= 1'b0;
            hold_vld  <= 1'b0;
            last_seen <= 1'b0;
`ifdef OQPSK_TX_CRC_EN
            crc       <= 16'hFFFF;
`endif
          end
        end
        PRE: begin
          if (bit_stb) begin
            if (cnt == PRE_LAST) begin
              state   <= SFD;
              cnt     <= '0;
              bit_out <= SFD_PATTERN[7];
            end else begin
              cnt     <= cnt + ONE;
              bit_out <= cnt[0];
            end
          end
        end
        SFD, PAY: begin
          if (bit_stb) begin
            if (cnt != BYTE_LAST) begin
              cnt <= cnt + ONE;
              if (state == SFD) begin
                bit_out <= SFD_PATTERN[3'd6 - cnt[2:0]];
              end else begin
                bit_out <= shreg[6];
                shreg   <= {shreg[6:0], 1'b0};
`ifdef OQPSK_TX_CRC_EN
                crc     <= crc16_step(crc, shreg[6]);
`endif
              end
            end else if ((state == PAY) && cur_last) begin
              cnt <= '0;
`ifdef OQPSK_TX_CRC_EN
              state   <= CRC;
              bit_out <= crc[15];
`else
              state   <= TAIL;
              bit_out <= 1'b0;
`endif
            end else if (hold_vld) begin
              state    <= PAY;
              cnt      <= '0;
              shreg    <= hold_data;
              cur_last <= hold_last;
              hold_vld <= 1'b0;
              bit_out  <= hold_data[7];
`ifdef OQPSK_TX_CRC_EN
              crc      <= crc16_step(crc, hold_data[7]);
`endif
            end else begin
              // Starved for a payload byte: abandon the payload and close the frame with the tail.
              state    <= TAIL;
              cnt      <= '0;
              bit_out  <= 1'b0;
              underrun <= 1'b1;
            end
          end
        end
`ifdef OQPSK_TX_CRC_EN
        CRC: begin
          if (bit_stb) begin
            if (cnt == CRC_LAST) begin
              state   <= TAIL;
              cnt     <= '0;
              bit_out <= 1'b0;
            end else begin
              cnt     <= cnt + ONE;
              bit_out <= crc[14];
              crc     <= {crc[14:0], 1'b0};
            end
          end
        end
`endif
        TAIL: begin
          if (bit_stb) begin
            bit_out <= 1'b0;
            if (cnt == TAIL_LAST) begin
              state  <= IDLE;
              cnt    <= '0;
              mod_en <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          bit_out <= 1'b0;
          mod_en  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oqpsk_tx_frame_ctrl.sv
// Scoreboard bench for oqpsk_tx_frame_ctrl: expected bit streams queued at start, popped per strobe.
module tb_oqpsk_tx_frame_ctrl;

  localparam int         PRE     = 4;
  localparam int         TAIL    = 4;
  localparam int         STB_PER = 25;
  localparam logic [7:0] SFD     = 8'hA7;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       bit_stb = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_last = 1'b0;
  logic       byte_valid = 1'b0;
  logic       byte_ready, bit_out, mod_en, busy, done, underrun;

  int          n_vec = 0;
  int          n_err = 0;
  int          stb_cnt = 0;
  logic [7:0]  pay[$];
  logic        exp_q[$];
  logic [15:0] crc_fixed = 16'h0000;
  bit          use_fixed = 1'b0;

  oqpsk_tx_frame_ctrl #(.PRE_BITS(PRE), .SFD_PATTERN(SFD), .TAIL_BITS(TAIL)) dut (
    .CLK(CLK), .RST(RST), .bit_stb(bit_stb), .start(start),
    .byte_data(byte_data), .byte_last(byte_last), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .bit_out(bit_out), .mod_en(mod_en), .busy(busy),
    .done(done), .underrun(underrun)
  );

  always #10 CLK = ~CLK;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [15:0] n;
    n = c << 1;
    if (c[15] ^ b) n = n ^ 16'h1021;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int n_supply, input bit hold_valid, input bit busy_start,
                           input bit coincide, input int abort_at, input string name);
    int idx = 0, nstb = 0, pre_acc = 0, pos = 0, j = 0;
    bit hs = 0, running = 0, start_edge = 0, stb_edge = 0, finished = 0;
    bit exp_ur, abort_pend = 0, ready_bad = 0, stop = 0;
    logic [15:0] crc;
    exp_q.delete();
    for (int k = 0; k < PRE; k++) exp_q.push_back((k % 2) == 0);
    for (int k = 7; k >= 0; k--) exp_q.push_back(SFD[k]);
    crc = 16'hFFFF;
    for (int i = 0; i < n_supply; i++)
      for (int k = 7; k >= 0; k--) begin
        exp_q.push_back(pay[i][k]);
        crc = crc_step(crc, pay[i][k]);
      end
    exp_ur = (n_supply < pay.size());
`ifdef OQPSK_TX_CRC_EN
    if (!exp_ur) begin
      if (use_fixed) crc = crc_fixed;
      for (int k = 15; k >= 0; k--) exp_q.push_back(crc[k]);
    end
`endif
    for (int k = 0; k < TAIL; k++) exp_q.push_back(1'b0);

    if (hold_valid) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge CLK);
        byte_valid = 1'b1;
        byte_data  = pay[0];
        byte_last  = (pay.size() == 1);
        if (c > 0) chk({name, "_ready_idle"}, byte_ready, 1'b0);
      end
    end

    @(negedge CLK);
    chk({name, "_idle_busy"}, busy, 1'b0);
    chk({name, "_idle_ready"}, byte_ready, 1'b0);
    start = 1'b1;
    if (coincide) begin
      stb_cnt = 0;
      bit_stb = 1'b1;
    end else begin
      stb_cnt = 5;
      bit_stb = 1'b0;
    end
    byte_valid = hold_valid || (n_supply > 0);
    byte_data  = pay[0];
    byte_last  = (pay.size() == 1);
    hs         = byte_valid & byte_ready;
    start_edge = 1'b1;
    stb_edge   = 1'b0;

    for (int cyc_n = 0; cyc_n < 5000 && !stop; cyc_n++) begin
      @(negedge CLK);
      if (RST) begin
        chk({name, "_rst_mod_en"}, mod_en, 1'b0);
        chk({name, "_rst_busy"}, busy, 1'b0);
        chk({name, "_rst_bit_out"}, bit_out, 1'b0);
        chk({name, "_rst_ready"}, byte_ready, 1'b0);
        chk({name, "_rst_underrun"}, underrun, 1'b0);
        RST = 1'b0;
        bit_stb = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        finished = 1'b1;
        stop = 1'b1;
      end else begin
        if (hs) begin
          if (nstb < PRE) pre_acc++;
          idx++;
        end
        if (finished) begin
          chk({name, "_done_one_cycle"}, done, 1'b0);
          stop = 1'b1;
        end else if (start_edge) begin
          chk({name, "_bit0"}, bit_out, exp_q.pop_front());
          chk({name, "_mod_en_on"}, mod_en, 1'b1);
          chk({name, "_busy_on"}, busy, 1'b1);
          chk({name, "_underrun_clr"}, underrun, 1'b0);
          running = 1'b1;
          start_edge = 1'b0;
          pos = 1;
        end else if (stb_edge && running) begin
          nstb++;
          if (exp_q.size() > 0) begin
            chk($sformatf("%s_bit%0d", name, pos), bit_out, exp_q.pop_front());
            pos++;
            if (abort_at != 0 && nstb == abort_at) abort_pend = 1'b1;
          end else begin
            chk({name, "_done"}, done, 1'b1);
            chk({name, "_mod_en_off"}, mod_en, 1'b0);
            chk({name, "_busy_off"}, busy, 1'b0);
            chk({name, "_bit_out_off"}, bit_out, 1'b0);
            chk({name, "_underrun"}, underrun, exp_ur);
            chk({name, "_length"}, pos, exp_ur ? PRE + 8 + 8 * n_supply + TAIL : pos);
            running = 1'b0;
            finished = 1'b1;
          end
        end
        if (running && idx >= pay.size() && byte_ready) ready_bad = 1'b1;

        if (abort_pend) begin
          RST = 1'b1;
          abort_pend = 1'b0;
        end
        start   = busy_start && running && (cyc_n == 40);
        stb_cnt = (stb_cnt + 1) % STB_PER;
        bit_stb = (stb_cnt == 0);
        j = (idx < pay.size()) ? idx : pay.size() - 1;
        byte_valid = hold_valid ? 1'b1 : (idx < n_supply);
        byte_data  = pay[j];
        byte_last  = (j == pay.size() - 1);
        hs       = byte_valid & byte_ready;
        stb_edge = bit_stb;
      end
    end
    chk({name, "_completed"}, finished, 1'b1);
    if (hold_valid) begin
      chk({name, "_pre_accepts"}, pre_acc, 1);
      chk({name, "_ready_after_last"}, ready_bad, 1'b0);
      chk({name, "_all_accepted"}, idx, pay.size());
    end
    start = 1'b0;
    bit_stb = 1'b0;
    byte_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_mod_en", mod_en, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_bit_out", bit_out, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_ready", byte_ready, 1'b0);
    chk("reset_underrun", underrun, 1'b0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // single byte 0x3C: reference bit sequence
    pay = '{8'h3C};
    run_frame(1, 1'b0, 1'b0, 1'b0, 0, "single");

    // start while busy is ignored
    run_frame(1, 1'b0, 1'b1, 1'b0, 0, "busy_start");

    // start coinciding with a strobe in IDLE
    pay = '{8'hE1};
    run_frame(1, 1'b0, 1'b0, 1'b1, 0, "coincide");

    // second byte withheld: underrun after byte 1, sticky until next start
    pay = '{8'h5A, 8'hC3};
    run_frame(1, 1'b0, 1'b0, 1'b0, 0, "underrun");
    repeat (30) @(negedge CLK);
    chk("underrun_sticky", underrun, 1'b1);

    // reset mid-payload, then a clean multi-byte frame
    pay = '{8'hF0, 8'h0F, 8'h81};
    run_frame(3, 1'b0, 1'b0, 1'b0, PRE + 8 + 3, "abort");
    repeat (3) @(negedge CLK);
    pay = '{8'h96, 8'h21};
    run_frame(2, 1'b0, 1'b0, 1'b0, 0, "clean");

    // byte_valid held high throughout
    pay = '{8'hAB, 8'hCD, 8'hEF};
    run_frame(3, 1'b1, 1'b0, 1'b0, 0, "hold_valid");

`ifdef OQPSK_TX_CRC_EN
    // check value of "123456789"
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    crc_fixed = 16'h29B1;
    use_fixed = 1'b1;
    run_frame(9, 1'b0, 1'b0, 1'b0, 0, "crc_check");
    use_fixed = 1'b0;
`endif

    repeat (5) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
